// File: rtl/ux607_aon_reload_timer_if.sv
// ---------------------------------------------------------------------------
// ux607_aon_reload_timer_if
// Control/status bundle between the AON config register bank (master) and
// the reload timer (slave).
//   io_reload   master->slave  WIDTH  reload value (register vector q)
//   io_prescale master->slave  PRE_W  tick every 2**io_prescale clocks
//   io_oneshot  master->slave  1      stop after first expiry
//   io_start    master->slave  1      1-cycle start/restart request
//   io_stop     master->slave  1      1-cycle stop request
//   io_pause    master->slave  1      level pause while running
//   io_irq_clr  master->slave  1      1-cycle clear of sticky irq
//   io_count    slave->master  WIDTH  current count
//   io_busy     slave->master  1      timer not idle
//   io_expire   slave->master  1      1-cycle expiry pulse
//   io_irq      slave->master  1      sticky expiry flag
// ---------------------------------------------------------------------------
interface ux607_aon_reload_timer_if #(
  parameter int WIDTH = 20,
  parameter int PRE_W = 4
);
  logic [WIDTH-1:0] io_reload;
  logic [PRE_W-1:0] io_prescale;
  logic             io_oneshot;
  logic             io_start;
  logic             io_stop;
  logic             io_pause;
  logic             io_irq_clr;
  logic [WIDTH-1:0] io_count;
  logic             io_busy;
  logic             io_expire;
  logic             io_irq;

  modport master (
    output io_reload, io_prescale, io_oneshot, io_start, io_stop, io_pause, io_irq_clr,
    input  io_count, io_busy, io_expire, io_irq
  );

  modport slave (
    input  io_reload, io_prescale, io_oneshot, io_start, io_stop, io_pause, io_irq_clr,
    output io_count, io_busy, io_expire, io_irq
  );
endinterface

// File: rtl/ux607_aon_reload_timer.sv
// ---------------------------------------------------------------------------
// ux607_aon_reload_timer
// Down-counting reload timer for the always-on cluster. Counts io_reload
// prescaled ticks, then emits a registered 1-cycle expiry pulse and sets a
// sticky interrupt. Periodic mode reloads from io_reload at each wrap;
// one-shot mode returns to idle.
// Ports:
//   clock  in  single clock, all state on rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of ux607_aon_reload_timer_if (controls + status)
// ---------------------------------------------------------------------------
module ux607_aon_reload_timer #(
  parameter int WIDTH = 20,
  parameter int PRE_W = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  ux607_aon_reload_timer_if.slave        bus
);

  // Prescaler must cover the largest divide, 2**(2**PRE_W - 1).
  localparam int PRE_CNT_W = (2 ** PRE_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  state_e                 r_state;
  logic [WIDTH-1:0]       r_count;
  logic [PRE_CNT_W-1:0]   r_pre_cnt;
  logic                   r_expire;
  logic                   r_irq;

  state_e                 w_state_nxt;
  logic [WIDTH-1:0]       w_count_nxt;
  logic [PRE_CNT_W-1:0]   w_pre_nxt;
  logic                   w_fire;
  logic [PRE_CNT_W-1:0]   w_mask;
  logic                   w_tick;
  logic                   w_reload_nz;

  // Low io_prescale bits set: mask = 2**io_prescale - 1. Taken live so a
  // prescale change applies immediately without disturbing the prescaler.
  assign w_mask      = ~({PRE_CNT_W{1'b1}} << bus.io_prescale);
  assign w_tick      = (r_state == ST_RUN) && ((r_pre_cnt & w_mask) == w_mask);
  assign w_reload_nz = (bus.io_reload != '0);

  // Next-state / datapath decode, priority: stop, start, then per-state.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre_cnt;
    w_fire      = 1'b0;

    if (bus.io_stop) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_pre_nxt   = '0;
    end else if (bus.io_start && w_reload_nz) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = bus.io_reload;
      w_pre_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.io_pause) begin
            // Pausing edge consumes no tick and holds the prescaler.
            w_state_nxt = ST_PAUSED;
          end else begin
            w_pre_nxt = r_pre_cnt + 1'b1;
            if (w_tick) begin
              if (r_count != WIDTH'(1)) begin
                w_count_nxt = r_count - 1'b1;
              end else begin
                w_fire = 1'b1;
                if (!bus.io_oneshot && w_reload_nz) begin
                  w_count_nxt = bus.io_reload;
                end else begin
                  w_state_nxt = ST_IDLE;
                  w_count_nxt = '0;
                  w_pre_nxt   = '0;
                end
              end
            end
          end
        end
        ST_PAUSED: begin
          if (!bus.io_pause) w_state_nxt = ST_RUN;
        end
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          // Unused encoding recovers to a clean idle.
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_pre_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_pre_cnt <= '0;
      r_expire  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_pre_cnt <= w_pre_nxt;
      r_expire  <= w_fire;
      // Set wins over clear both at the expiring edge and while the pulse is
      // presented, so a clear coincident with an expiry never loses it.
      r_irq     <= w_fire | r_expire | (r_irq & ~bus.io_irq_clr);
    end
  end

  assign bus.io_count  = r_count;
  assign bus.io_busy   = (r_state != ST_IDLE);
  assign bus.io_expire = r_expire;
  assign bus.io_irq    = r_irq;

endmodule

// File: tb/tb_ux607_aon_reload_timer.sv
// ---------------------------------------------------------------------------
// tb_ux607_aon_reload_timer
// Scoreboard bench: each driven cycle advances a behavioural model of the
// timer and queues the expected outputs; a monitor compares after each edge.
// ---------------------------------------------------------------------------
module tb_ux607_aon_reload_timer;

  localparam int WIDTH = 20;
  localparam int PRE_W = 4;

  typedef struct {
    logic [WIDTH-1:0] reload;
    logic [PRE_W-1:0] prescale;
    logic             oneshot;
    logic             start;
    logic             stop;
    logic             pause;
    logic             irq_clr;
  } stim_t;

  typedef struct {
    int count;
    bit busy;
    bit expire;
    bit irq;
  } resp_t;

  logic clock;
  logic reset;

  ux607_aon_reload_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  ux607_aon_reload_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_vectors = 0;
  int    n_fail    = 0;
  resp_t exp_q[$];
  stim_t cur;

  // Behavioural model: timer is "armed" or not, possibly frozen; ticks come
  // every 2**prescale run cycles counted since the last start.
  bit m_armed, m_frozen, m_expire, m_irq;
  int m_count, m_runcyc;

  task automatic check(input string name, input int act, input int exp);
    n_vectors++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_armed  = 0;
    m_frozen = 0;
    m_expire = 0;
    m_irq    = 0;
    m_count  = 0;
    m_runcyc = 0;
  endtask

  task automatic model_step(input stim_t s);
    bit pulse_now;
    bit fired;
    int period;
    pulse_now = m_expire;
    fired     = 0;
    period    = 1 << s.prescale;
    if (s.stop) begin
      m_armed = 0; m_frozen = 0; m_count = 0; m_runcyc = 0;
    end else if (s.start && s.reload != 0) begin
      m_armed = 1; m_frozen = 0; m_count = int'(s.reload); m_runcyc = 0;
    end else if (m_armed && !m_frozen) begin
      if (s.pause) begin
        m_frozen = 1;
      end else begin
        if ((m_runcyc % period) == period - 1) begin
          if (m_count > 1) begin
            m_count = m_count - 1;
          end else begin
            fired = 1;
            if (!s.oneshot && s.reload != 0) m_count = int'(s.reload);
            else begin m_armed = 0; m_count = 0; m_runcyc = -1; end
          end
        end
        m_runcyc++;
      end
    end else if (m_armed && m_frozen && !s.pause) begin
      m_frozen = 0;
    end
    m_irq    = fired || pulse_now || (m_irq && !s.irq_clr);
    m_expire = fired;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the model's
  // prediction for the following rising edge.
  task automatic drive(input stim_t s);
    resp_t r;
    @(negedge clock);
    bus.io_reload   = s.reload;
    bus.io_prescale = s.prescale;
    bus.io_oneshot  = s.oneshot;
    bus.io_start    = s.start;
    bus.io_stop     = s.stop;
    bus.io_pause    = s.pause;
    bus.io_irq_clr  = s.irq_clr;
    model_step(s);
    r.count  = m_count;
    r.busy   = m_armed;
    r.expire = m_expire;
    r.irq    = m_irq;
    exp_q.push_back(r);
  endtask

  task automatic step();
    drive(cur);
    cur.start   = 1'b0;
    cur.stop    = 1'b0;
    cur.irq_clr = 1'b0;
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    resp_t r;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("count",  int'(bus.io_count),  r.count);
        check("busy",   int'(bus.io_busy),   int'(r.busy));
        check("expire", int'(bus.io_expire), int'(r.expire));
        check("irq",    int'(bus.io_irq),    int'(r.irq));
      end
    end
  end

  initial begin
    int exp_seq[6];
    bit seen;
    exp_seq = '{5, 4, 3, 2, 1, 5};

    cur = '{reload: '0, prescale: '0, oneshot: 1'b0, start: 1'b0,
            stop: 1'b0, pause: 1'b0, irq_clr: 1'b0};
    bus.io_reload = '0; bus.io_prescale = '0; bus.io_oneshot = 1'b0;
    bus.io_start = 1'b0; bus.io_stop = 1'b0; bus.io_pause = 1'b0;
    bus.io_irq_clr = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    check("rst_count",  int'(bus.io_count),  0);
    check("rst_busy",   int'(bus.io_busy),   0);
    check("rst_expire", int'(bus.io_expire), 0);
    check("rst_irq",    int'(bus.io_irq),    0);
    @(negedge clock);
    reset = 1'b1;

    // 1: periodic, reload 5, no prescale.
    cur.reload = 20'd5; cur.prescale = 4'd0; cur.oneshot = 1'b0; cur.start = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("t1_count",  int'(bus.io_count),  exp_seq[i]);
      check("t1_expire", int'(bus.io_expire), (i == 5) ? 1 : 0);
    end
    cur.stop = 1'b1;
    step();

    // 2: one-shot, reload 3, prescale 2 -> expiry 12 clocks after start.
    cur.reload = 20'd3; cur.prescale = 4'd2; cur.oneshot = 1'b1; cur.start = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      step();
      check("t2_expire", int'(bus.io_expire), (i == 12) ? 1 : 0);
      if (i >= 12) begin
        check("t2_count", int'(bus.io_count), 0);
        check("t2_busy",  int'(bus.io_busy),  0);
        check("t2_irq",   int'(bus.io_irq),   1);
      end
    end

    // 3: clear while the pulse is presented keeps irq; a later clear drops it.
    cur.irq_clr = 1'b1;
    step();
    cur.reload = 20'd2; cur.prescale = 4'd0; cur.oneshot = 1'b1; cur.start = 1'b1;
    step();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (m_expire) begin
        seen = 1;
        cur.irq_clr = 1'b1;
        step();
        step();
        check("t3_irq_kept", int'(bus.io_irq), 1);
        cur.irq_clr = 1'b1;
        step();
        step();
        check("t3_irq_clr", int'(bus.io_irq), 0);
      end else begin
        step();
      end
    end
    check("t3_pulse_seen", int'(seen), 1);

    // 4: zero reload start is ignored; stop beats start.
    cur.reload = 20'd0; cur.oneshot = 1'b0; cur.start = 1'b1;
    step();
    step();
    check("t4_zero_busy",  int'(bus.io_busy),  0);
    check("t4_zero_count", int'(bus.io_count), 0);
    cur.reload = 20'd4; cur.start = 1'b1;
    step(); step(); step();
    cur.stop = 1'b1; cur.start = 1'b1;
    step();
    step();
    check("t4_stop_busy",  int'(bus.io_busy),  0);
    check("t4_stop_count", int'(bus.io_count), 0);

    // 5: pause mid-run holds the count.
    cur.reload = 20'd8; cur.prescale = 4'd0; cur.oneshot = 1'b0; cur.start = 1'b1;
    step();
    repeat (3) step();
    cur.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_hold", int'(bus.io_count), 5);
    end
    cur.pause = 1'b0;
    repeat (20) step();

    // 6: asynchronous reset mid-run with count 4.
    cur.reload = 20'd8; cur.start = 1'b1;
    step();
    repeat (4) step();
    @(posedge clock);
    #3;
    check("t6_pre_count", int'(bus.io_count), 4);
    check("t6_pre_irq",   int'(bus.io_irq),   1);
    reset = 1'b0;
    #1;
    check("t6_count",  int'(bus.io_count),  0);
    check("t6_busy",   int'(bus.io_busy),   0);
    check("t6_irq",    int'(bus.io_irq),    0);
    check("t6_expire", int'(bus.io_expire), 0);
    model_reset();
    cur.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Randomised traffic against the model.
    cur.pause = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) cur.reload = WIDTH'($urandom_range(0, 10));
      if ($urandom_range(0, 99) < 3)
        cur.prescale = PRE_W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                                           : $urandom_range(0, 2));
      if ($urandom_range(0, 99) < 5) cur.pause = ~cur.pause;
      cur.start = ($urandom_range(0, 99) < 6);
      if (cur.start) begin
        cur.oneshot = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0 && cur.reload == 0) cur.reload = WIDTH'($urandom_range(1, 9));
      end
      cur.stop    = ($urandom_range(0, 99) < 2);
      cur.irq_clr = ($urandom_range(0, 99) < 8);
      step();
    end

    repeat (3) @(posedge clock);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule
